// File: rtl/uart_string_monitor.sv
// UART memory-protocol client: reads a length-prefixed string,
// prints it, writes back a completion word, then halts.
module uart_string_monitor #(
  parameter int CLK       = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic res,
  input  logic rx,
  output logic tx
);

  localparam int DIV  = (CLK * 1000000) / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_RD_LEN,
    S_RD_WORD,
    S_PRINT,
    S_WR_DONE,
    S_HLT,
    S_DONE
  } state_t;

  function automatic logic [7:0] byte_sel(
    input logic [31:0] w,
    input logic [1:0]  s
  );
    logic [7:0] r;
    unique case (s)
      2'd0: r = w[7:0];
      2'd1: r = w[15:8];
      2'd2: r = w[23:16];
      2'd3: r = w[31:24];
    endcase
    return r;
  endfunction

  logic rx_s1;
  logic rx_s2;
  logic rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [3:0] rx_bit;
  logic [7:0] rx_sh;
  logic rx_valid;

  logic tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0] tx_bit;
  logic [9:0] tx_sh;
  logic tx_go;
  logic [7:0] tx_byte;
  logic tx_idle;

  state_t state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        wait_q, wait_d;
  logic [1:0]  rcnt_q, rcnt_d;
  logic [31:0] word_q, word_d;
  logic [15:0] len_q, len_d;
  logic [15:0] n_q, n_d;
  logic [1:0]  bidx_q, bidx_d;

  logic [31:0] rd_addr;
  logic [31:0] cmd_word;
  logic [1:0]  bsel;

  // two-flop synchronizer on the serial input
  always_ff @(posedge clk) begin
    if (res) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // receiver: confirm start at half bit, sample centres, emit at stop
  always_ff @(posedge clk) begin
    if (res) begin
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt <= '0;
          if (rx_s2) rx_busy <= 1'b0;
          else rx_bit <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (rx_cnt == DIV_LAST) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_valid <= 1'b1;
        end else begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  // transmitter: shifts a 10-bit 8N1 frame, accepts only when idle
  always_ff @(posedge clk) begin
    if (res) begin
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (!tx_busy) begin
      if (tx_go) begin
        tx_busy <= 1'b1;
        tx_cnt  <= '0;
        tx_bit  <= '0;
        tx_sh   <= {1'b1, tx_byte, 1'b0};
      end
    end else if (tx_cnt == DIV_LAST) begin
      tx_cnt <= '0;
      tx_sh  <= {1'b1, tx_sh[9:1]};
      if (tx_bit == 4'd9) tx_busy <= 1'b0;
      else tx_bit <= tx_bit + 1'b1;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign tx      = tx_busy ? tx_sh[0] : 1'b1;
  assign tx_idle = !tx_busy;

  assign rd_addr = 32'd4 + {16'd0, n_q & 16'hfffc};
  assign bsel    = idx_q[1:0] - 2'd1;

  // operand word whose bytes follow the command code
  always_comb begin
    cmd_word = 32'd0;
    if (state_q == S_RD_WORD) begin
      cmd_word = rd_addr;
    end else if (state_q == S_WR_DONE && idx_q >= 4'd5) begin
      cmd_word = {16'h600d, len_q};
    end
  end

  // sequencer state and datapath registers
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      wait_q  <= 1'b0;
      rcnt_q  <= '0;
      word_q  <= '0;
      len_q   <= '0;
      n_q     <= '0;
      bidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      rcnt_q  <= rcnt_d;
      word_q  <= word_d;
      len_q   <= len_d;
      n_q     <= n_d;
      bidx_q  <= bidx_d;
    end
  end

  // sequencer next state: byte issue, reply collection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    rcnt_d  = rcnt_q;
    word_d  = word_q;
    len_d   = len_q;
    n_d     = n_q;
    bidx_d  = bidx_q;
    tx_go   = 1'b0;
    tx_byte = 8'h00;
    if (wait_q) begin
      if (rx_valid) begin
        word_d = {word_q[23:0], rx_sh};
        rcnt_d = rcnt_q + 2'd1;
        if (rcnt_q == 2'd3) begin
          wait_d = 1'b0;
          idx_d  = '0;
          if (state_q == S_RD_LEN) begin
            len_d   = word_d[15:0];
            n_d     = '0;
            state_d = S_RD_WORD;
          end else begin
            bidx_d  = '0;
            state_d = S_PRINT;
          end
        end
      end
    end else begin
      unique case (state_q)
        S_INIT: begin
          idx_d   = '0;
          state_d = S_RD_LEN;
        end
        S_RD_LEN, S_RD_WORD: begin
          if (state_q == S_RD_WORD && idx_q == 4'd0
              && n_q >= len_q) begin
            state_d = S_WR_DONE;
          end else if (tx_idle) begin
            tx_go   = 1'b1;
            tx_byte = (idx_q == 4'd0) ? 8'h01
                                      : byte_sel(cmd_word, bsel);
            if (idx_q == 4'd4) begin
              idx_d  = '0;
              wait_d = 1'b1;
              rcnt_d = '0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        S_PRINT: begin
          if (tx_idle) begin
            tx_go = 1'b1;
            if (idx_q == 4'd0) begin
              tx_byte = 8'h03;
              idx_d   = 4'd1;
            end else begin
              tx_byte = byte_sel(word_q, ~bidx_q);
              idx_d   = '0;
              n_d     = n_q + 16'd1;
              bidx_d  = bidx_q + 2'd1;
              if (bidx_q == 2'd3 || n_d >= len_q) begin
                state_d = S_RD_WORD;
              end
            end
          end
        end
        S_WR_DONE: begin
          if (tx_idle) begin
            tx_go   = 1'b1;
            tx_byte = (idx_q == 4'd0) ? 8'h02
                                      : byte_sel(cmd_word, bsel);
            if (idx_q == 4'd8) begin
              idx_d   = '0;
              state_d = S_HLT;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        S_HLT: begin
          if (tx_idle) begin
            tx_go   = 1'b1;
            tx_byte = 8'h04;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_string_monitor.sv
// Bench for uart_string_monitor: UART memory server model with
// an expected-byte scoreboard checked by the tx monitor.
module tb_uart_string_monitor;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  uart_string_monitor #(
    .CLK(1),
    .BAUD_RATE(100000)
  ) dut (
    .clk(clk),
    .res(res),
    .rx(rx),
    .tx(tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rxq[$];
  logic [7:0] printed[$];
  logic [7:0] mem [0:63];
  bit halted = 0;
  bit glitch_arm = 0;
  int scmd = 0;
  int scnt = 0;
  logic [31:0] saddr = 0;
  logic [31:0] sdata = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_n(int n, output bit ab);
    ab = 0;
    for (int i = 0; i < n && !ab; i++) begin
      @(posedge clk);
      #1;
      if (res) ab = 1;
    end
  endtask

  task automatic handle_byte(logic [7:0] b);
    logic [7:0] e;
    int a;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL tx byte: got %0h, required none", b);
    end else begin
      e = exp_q.pop_front();
      chk("tx byte", b, e);
    end
    if (scnt == 0) begin
      scmd = b;
      scnt = (b == 1 || b == 2 || b == 3) ? 1 : 0;
      if (b == 4) halted = 1;
    end else if (scmd == 3) begin
      printed.push_back(b);
      scnt = 0;
    end else begin
      if (scnt <= 4) saddr[8*(scnt-1) +: 8] = b;
      else sdata[8*(scnt-5) +: 8] = b;
      a = int'(saddr[5:0]);
      if (scmd == 1 && scnt == 4) begin
        for (int k = 0; k < 4; k++) rxq.push_back(mem[a+k]);
        scnt = 0;
      end else if (scmd == 2 && scnt == 8) begin
        mem[a]   = sdata[31:24];
        mem[a+1] = sdata[23:16];
        mem[a+2] = sdata[15:8];
        mem[a+3] = sdata[7:0];
        scnt = 0;
      end else begin
        scnt++;
      end
    end
  endtask

  // tx monitor + memory server
  initial begin
    logic [7:0] mb;
    bit mab;
    forever begin
      @(posedge clk);
      #1;
      if (res) begin
        scnt = 0;
        rxq.delete();
        printed.delete();
        halted = 0;
      end else if (tx === 1'b0) begin
        mb = 8'h00;
        wait_n(5, mab);
        if (!mab && tx == 1'b0) begin
          for (int i = 0; i < 8 && !mab; i++) begin
            wait_n(DIV, mab);
            mb[i] = tx;
          end
          if (!mab) wait_n(DIV, mab);
          if (!mab) begin
            chk("stop bit", tx, 1);
            handle_byte(mb);
          end
        end
      end
    end
  end

  // rx driver for reply bytes
  initial begin
    logic [7:0] sb;
    forever begin
      @(negedge clk);
      if (!res && rxq.size() > 0) begin
        if (glitch_arm) begin
          rx = 1'b0;
          repeat (2) @(negedge clk);
          rx = 1'b1;
          repeat (20) @(negedge clk);
          glitch_arm = 0;
        end
        sb = rxq.pop_front();
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx = sb[i];
          repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
        repeat (DIV) @(negedge clk);
      end
    end
  end

  task automatic load(logic [31:0] w0, string s);
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = w0[31:24];
    mem[1] = w0[23:16];
    mem[2] = w0[15:8];
    mem[3] = w0[7:0];
    for (int i = 0; i < s.len(); i++) mem[4+i] = s[i];
  endtask

  task automatic push_rd(logic [7:0] a);
    exp_q.push_back(8'h01);
    exp_q.push_back(a);
    repeat (3) exp_q.push_back(8'h00);
  endtask

  task automatic push_pr(string s);
    for (int i = 0; i < s.len(); i++) begin
      exp_q.push_back(8'h03);
      exp_q.push_back(s[i]);
    end
  endtask

  task automatic push_wr(logic [15:0] l);
    exp_q.push_back(8'h02);
    repeat (4) exp_q.push_back(8'h00);
    exp_q.push_back(l[7:0]);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h60);
    exp_q.push_back(8'h04);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    res = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("tx high in reset", tx, 1);
    end
  endtask

  task automatic release_reset();
    int lat;
    @(negedge clk);
    res = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (tx == 1'b0) lat = i;
    end
    chk("start latency", (lat >= 1 && lat <= 4), 1);
  endtask

  task automatic finish_seq(string s, logic [31:0] w0);
    int cyc;
    bit low;
    cyc = 0;
    while (!halted && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    chk("halt seen", halted, 1);
    low = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (tx == 1'b0) low = 1;
    end
    chk("done idle", low, 0);
    chk("bytes left", exp_q.size(), 0);
    chk("print len", printed.size(), s.len());
    for (int i = 0; i < s.len() && i < printed.size(); i++) begin
      chk("print char", printed[i], s[i]);
    end
    chk("mem word0", {mem[0], mem[1], mem[2], mem[3]}, w0);
  endtask

  initial begin
    int cyc;
    // Hello, L=5
    hold_reset();
    load(32'h00000005, "Hello");
    push_rd(8'h00);
    push_rd(8'h04);
    push_pr("Hell");
    push_rd(8'h08);
    push_pr("o");
    push_wr(16'h0005);
    release_reset();
    finish_seq("Hello", 32'h600d0005);

    // L=0
    hold_reset();
    load(32'h00000000, "");
    push_rd(8'h00);
    push_wr(16'h0000);
    release_reset();
    finish_seq("", 32'h600d0000);

    // L=6 with a glitch ahead of the first reply
    hold_reset();
    load(32'hffff0006, "ABCDEFGH");
    glitch_arm = 1;
    push_rd(8'h00);
    push_rd(8'h04);
    push_pr("ABCD");
    push_rd(8'h08);
    push_pr("EF");
    push_wr(16'h0006);
    release_reset();
    finish_seq("ABCDEF", 32'h600d0006);
    chk("glitch issued", glitch_arm, 0);

    // reset in the third PRINT-phase frame, then full rerun
    hold_reset();
    load(32'h00000005, "Hello");
    push_rd(8'h00);
    push_rd(8'h04);
    push_pr("H");
    release_reset();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 8000) begin
      @(posedge clk);
      cyc++;
    end
    chk("prefix seen", exp_q.size(), 0);
    repeat (40) @(posedge clk);
    hold_reset();
    exp_q.delete();
    push_rd(8'h00);
    push_rd(8'h04);
    push_pr("Hell");
    push_rd(8'h08);
    push_pr("o");
    push_wr(16'h0005);
    release_reset();
    finish_seq("Hello", 32'h600d0005);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_string_monitor.md
# uart_string_monitor

Self-contained SoC-level block that drives an external UART memory server: it reads a length-prefixed string from remote memory, prints it through the server's print command, writes back a completion word, and issues halt. It is the top-level design of the UART memory-protocol bring-up, with only clock, reset and the two serial lines at its boundary. A UART receiver, a UART transmitter and a protocol sequencer all live inside.

## Interface
- CLK, default 50: core clock frequency in MHz.
- BAUD_RATE, default 115200: serial bit rate. Bit period `DIV = CLK*1_000_000/BAUD_RATE` clocks, integer truncated, DIV ≥ 4 required.
- clk  in  1  single clock; all logic is rising-edge.
- res  in  1  reset, synchronous, active-high.
- rx  in  1  serial input from the memory server; idle high.
- tx  out  1  serial output to the memory server; idle high.

## Operation
- Serial format is 8N1, LSB first:
  - start bit low, 8 data bits, stop bit high; each bit lasts DIV clocks, one byte frame is 10·DIV clocks.
  - tx idles high; there is no inter-byte gap requirement.
- Command codes: READ=0x01, WRITE=0x02, PRINT=0x03, HLT=0x04.
- Addresses are sent as 4 bytes, addr[7:0] first.
- WRITE data is sent as 4 bytes, data[7:0] first.
- A READ reply is 4 bytes, most significant first: word = {b0,b1,b2,b3}, i.e. big-endian memory order {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
- Sequencer states: INIT → RD_LEN → RD_WORD → PRINT → WR_DONE → HLT → DONE.
  - RD_LEN: send READ addr 0 and receive 4 bytes. L = word[15:0]; word[31:16] is ignored. Reset counter n=0.
  - RD_WORD: if n ≥ L, go to WR_DONE. Otherwise send READ with addr 4+(n & ~3) and receive the word.
  - PRINT: for each byte of the word, MSB first, send PRINT followed by the character while n < L, incrementing n after each. After 4 bytes, or once n reaches L, return to RD_WORD.
  - WR_DONE: send WRITE, addr 0, data 0x600D0000 | L.
  - HLT: send 0x04, then enter DONE.
  - DONE: terminal state, tx held high until reset.
- Receiver:
  - rx passes through a 2-flop synchronizer.
  - A low level on an idle line starts a frame. Sample at DIV/2 to confirm the start bit; if rx is high there, the frame is discarded as a glitch.
  - The 8 data bits are sampled at their bit centres.
  - The byte is delivered at the centre of the stop bit. A framing error (low stop bit) is ignored and the byte is still delivered.
  - The receiver is ready for the next start bit immediately after the stop-bit sample.
- Bytes received while the sequencer is not awaiting a reply are dropped.
- Transmitter accepts a byte only when idle. The sequencer issues the next byte on the cycle after the previous frame completes.

## Timing
- During reset and on the first cycle after it: tx=1, all state returns to INIT, and the receiver and transmitter return to idle.
- The first start bit (READ 0x01) begins no later than 4 clocks after res deasserts.
- Reset asserted mid-frame or mid-sequence:
  - tx goes high on the next edge; the partial frame is abandoned.
  - After release, the sequence restarts from RD_LEN.
- Reply wait has no timeout; the sequencer waits indefinitely for the 4 reply bytes.
- Reply bytes may begin immediately after the DUT's last stop bit. The receiver must catch a start bit that arrives on the first bit period after the DUT's final stop bit.
- A byte is output on tx within 2 clocks of the transmitter going idle while the sequencer has data pending.
- Counter n and L are 16-bit. Address arithmetic is 32-bit, with no wrap for L ≤ 65535.

## Test plan
- Reset: hold res 5 cycles → tx=1 throughout. The first falling edge follows within 4 clocks of release, then byte 0x01 and addr bytes 00 00 00 00, at DIV=10 (CLK=1, BAUD_RATE=100000) each bit lasting 10 clocks.
- Memory bytes 00 00 00 05 "Hello" at 0..8:
  - Printed stream is "Hello" (5 PRINT pairs) after READs of 0 and 4, 8.
  - Then WRITE addr 0 with bytes 05 00 0D 60, then 0x04.
  - Afterwards memory[0..3] = 60 0D 00 05.
- L=0: READ 0 → no print. WRITE 0 with data 0x600D0000, then HLT. No READ at addr 4.
- L=6, "ABCDEFGH" at 4: reads at 4 and 8, prints "ABCDEF" only (G,H not printed).
- Reset asserted during the 3rd PRINT frame: tx high next cycle. After release, the sequence restarts with READ 0 and the full string is printed.
- Glitch: 2-clock low pulse on rx while awaiting a reply → ignored; the reply assembled from the next 4 valid frames is correct.
